// File: rtl/msi_bus_arbiter_pkg.sv
// Shared types and constants for the MSI snoop-bus arbiter and the cache
// controllers that sit on either side of it.
//   arb_state_t        : arbiter sequencing states
//   SOURCE_DMEM        : cpu_datasel code, fill data comes from unified memory
//   SOURCE_OTHER_PROC  : cpu_datasel code, fill data comes from the other cache
package msi_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        SNOOP,
        RESP,
        MEM_XFER
    } arb_state_t;

    localparam logic [1:0] SOURCE_DMEM       = 2'b00;
    localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;

endpackage

// File: rtl/msi_bus_arbiter_rr_arb2.sv
// Two-requester round-robin picker with a registered priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> CPU0)
//   req        : request per requester
//   take       : the pick is being consumed this cycle (pointer moves)
//   win        : index of the selected requester (valid when any = 1)
//   any        : at least one requester is asking
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       win,
    output logic       any
);

    logic rr;

    // rr only matters when both request; a lone requester always wins.
    always_comb begin
        any = |req;
        win = req[1] & (~req[0] | rr);
    end

    // Pointer moves to the loser of every consumed pick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 1'b0;
        else if (take && any)
            rr <= ~win;
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// MSI coherence bus arbiter for two cache controllers (CPU0, CPU1).
// Picks one owner per transaction, snoops the other cache on misses,
// selects the fill data source, broadcasts invalidates and hands the
// unified memory port to the owner.
// Optional build macro ARB_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_req[1:0]                per-CPU unified-memory request (level)
//   read_miss/write_miss[1:0]   per-CPU miss pulses (latched until serviced)
//   invalidate_req[1:0]         per-CPU write-hit-on-SHARED pulse (latched)
//   bico0, bico1                per-CPU outgoing bus address
//   search_found[1:0]           per-CPU snoop hit
//   mem_rdy                     unified memory ready
//   grant[1:0]                  one-hot bus grant
//   cpu_search[1:0]             snoop request to the non-owner
//   boci0, boci1                address into each CPU's snoop port
//   inv_to[1:0]                 invalidate from the other CPU
//   datasel0, datasel1          fill data source per CPU
//   mem_owner                   CPU index driving unified memory
//   busy                        arbiter not idle
//   grant_cnt0/1, snoop_hit_cnt, timeout_cnt   (ARB_STATS_EN only)
module msi_bus_arbiter
    import msi_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int SNOOP_LAT   = 1,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mem_req,
    input  logic [1:0]        read_miss,
    input  logic [1:0]        write_miss,
    input  logic [1:0]        invalidate_req,
    input  logic [ADDR_W-1:0] bico0,
    input  logic [ADDR_W-1:0] bico1,
    input  logic [1:0]        search_found,
    input  logic              mem_rdy,
    output logic [1:0]        grant,
    output logic [1:0]        cpu_search,
    output logic [ADDR_W-1:0] boci0,
    output logic [ADDR_W-1:0] boci1,
    output logic [1:0]        inv_to,
    output logic [1:0]        datasel0,
    output logic [1:0]        datasel1,
    output logic              mem_owner,
    output logic              busy
`ifdef ARB_STATS_EN
   ,output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       snoop_hit_cnt,
    output logic [7:0]        timeout_cnt
`endif
);

    localparam int              TW         = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0]   T_LAST     = TW'(MEM_TIMEOUT - 1);
    localparam logic [1:0]      SNOOP_LAST = 2'(SNOOP_LAT - 1);

    arb_state_t        state, state_n;
    logic              owner, owner_n;
    logic              is_wr, hit_q;
    logic [1:0]        scnt;
    logic [TW-1:0]     tcnt;
    logic [1:0]        rm_pend, wm_pend, inv_pend;
    logic [1:0]        rm_e, wm_e, inv_e, req;
    logic [1:0]        svc_inv, svc_miss;
    logic [1:0]        oh, ot;
    logic [ADDR_W-1:0] bico_o;
    logic              win, any, take, timeout, forced;

    // Live pulses count as requests in the same cycle they arrive.
    assign rm_e  = rm_pend  | read_miss;
    assign wm_e  = wm_pend  | write_miss;
    assign inv_e = inv_pend | invalidate_req;
    assign req   = mem_req | rm_e | wm_e | inv_e;
    assign take  = (state == IDLE);

    rr_arb2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .take  (take),
        .win   (win),
        .any   (any)
    );

    assign oh      = owner ? 2'b10 : 2'b01;
    assign ot      = ~oh;
    assign bico_o  = owner ? bico1 : bico0;
    assign timeout = (tcnt == T_LAST);
    assign forced  = (state == MEM_XFER) && mem_req[owner] && !mem_rdy && timeout;

    // Next state and service strobes.
    always_comb begin
        state_n  = state;
        owner_n  = owner;
        svc_inv  = 2'b00;
        svc_miss = 2'b00;
        case (state)
            IDLE: if (any) begin
                owner_n = win;
                if (inv_e[win]) begin
                    state_n      = INV;
                    svc_inv[win] = 1'b1;
                end else if (rm_e[win] || wm_e[win]) begin
                    state_n       = SNOOP;
                    svc_miss[win] = 1'b1;
                end else begin
                    state_n = MEM_XFER;
                end
            end
            INV:      state_n = IDLE;
            SNOOP:    if (scnt == SNOOP_LAST) state_n = RESP;
            RESP:     state_n = mem_req[owner] ? MEM_XFER : IDLE;
            MEM_XFER: if (!mem_req[owner] || mem_rdy || timeout) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Outputs decode from registered state only (plus the owner's address),
    // so reset forces them all to zero without waiting for a clock.
    always_comb begin
        grant      = 2'b00;
        cpu_search = 2'b00;
        inv_to     = 2'b00;
        boci0      = '0;
        boci1      = '0;
        datasel0   = SOURCE_DMEM;
        datasel1   = SOURCE_DMEM;
        mem_owner  = 1'b0;
        busy       = (state != IDLE);
        if (state != IDLE) grant = oh;
        case (state)
            INV, SNOOP: begin
                if (state == INV) inv_to     = ot;
                else              cpu_search = ot;
                if (owner) boci0 = bico_o;
                else       boci1 = bico_o;
            end
            RESP: begin
                if (owner) datasel1 = hit_q ? SOURCE_OTHER_PROC : SOURCE_DMEM;
                else       datasel0 = hit_q ? SOURCE_OTHER_PROC : SOURCE_DMEM;
                if (is_wr) inv_to = ot;
            end
            MEM_XFER: mem_owner = owner;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            is_wr    <= 1'b0;
            hit_q    <= 1'b0;
            scnt     <= '0;
            tcnt     <= '0;
            rm_pend  <= '0;
            wm_pend  <= '0;
            inv_pend <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            if (state == IDLE && any) is_wr <= wm_e[win];
            if (state == SNOOP && scnt == SNOOP_LAST) hit_q <= search_found[~owner];
            scnt <= (state == SNOOP)    ? scnt + 2'd1     : '0;
            tcnt <= (state == MEM_XFER) ? tcnt + TW'(1)   : '0;
            // A CPU whose block is being invalidated while its own
            // invalidate is still waiting no longer holds the line, so the
            // waiting invalidate turns into a write miss.
            for (int i = 0; i < 2; i++) begin
                rm_pend[i]  <= rm_e[i] & ~svc_miss[i];
                wm_pend[i]  <= (wm_e[i] & ~svc_miss[i]) | (inv_e[i] & inv_to[i]);
                inv_pend[i] <= inv_e[i] & ~svc_inv[i] & ~inv_to[i];
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0    <= '0;
            grant_cnt1    <= '0;
            snoop_hit_cnt <= '0;
            timeout_cnt   <= '0;
        end else begin
            if (take && any && !win && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (take && any &&  win && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 16'd1;
            if (state == RESP && hit_q && snoop_hit_cnt != '1)
                snoop_hit_cnt <= snoop_hit_cnt + 16'd1;
            if (forced && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: stimulus pushes the expected output
// snapshot of every busy cycle; a negedge monitor pops and compares.
module tb_msi_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mem_req = '0, read_miss = '0, write_miss = '0, invalidate_req = '0;
    logic [12:0] bico0 = '0, bico1 = '0;
    logic [1:0]  search_found = '0;
    logic        mem_rdy = 1'b0;
    logic [1:0]  grant, cpu_search, inv_to, datasel0, datasel1;
    logic [12:0] boci0, boci1;
    logic        mem_owner, busy;
`ifdef ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, snoop_hit_cnt;
    logic [7:0]  timeout_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  g;
        logic [1:0]  s;
        logic [12:0] b0;
        logic [12:0] b1;
        logic [1:0]  inv;
        logic [1:0]  d0;
        logic [1:0]  d1;
        logic        own;
    } obs_t;

    obs_t sbq[$];

    msi_bus_arbiter #(.ADDR_W(13), .SNOOP_LAT(1), .MEM_TIMEOUT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .read_miss      (read_miss),
        .write_miss     (write_miss),
        .invalidate_req (invalidate_req),
        .bico0          (bico0),
        .bico1          (bico1),
        .search_found   (search_found),
        .mem_rdy        (mem_rdy),
        .grant          (grant),
        .cpu_search     (cpu_search),
        .boci0          (boci0),
        .boci1          (boci1),
        .inv_to         (inv_to),
        .datasel0       (datasel0),
        .datasel1       (datasel1),
        .mem_owner      (mem_owner),
        .busy           (busy)
`ifdef ARB_STATS_EN
       ,.grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .snoop_hit_cnt  (snoop_hit_cnt),
        .timeout_cnt    (timeout_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_busy(input logic [1:0] g, input logic [1:0] s,
                               input logic [12:0] b0, input logic [12:0] b1,
                               input logic [1:0] inv, input logic [1:0] d0,
                               input logic [1:0] d1, input logic own);
        obs_t e;
        e = '{g: g, s: s, b0: b0, b1: b1, inv: inv, d0: d0, d1: d1, own: own};
        sbq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_req = '0; read_miss = '0; write_miss = '0; invalidate_req = '0;
        mem_rdy = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every busy cycle must match the next expected snapshot.
    always @(negedge clk) begin
        obs_t got, e;
        if (rst_n && busy) begin
            got = '{g: grant, s: cpu_search, b0: boci0, b1: boci1, inv: inv_to,
                    d0: datasel0, d1: datasel1, own: mem_owner};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %h want idle", got);
            end else begin
                e = sbq.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_cycle got %h want %h", got, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_outs", 64'({grant, cpu_search, inv_to, datasel0, datasel1,
                               mem_owner, busy, boci0, boci1}), 64'd0);
        do_reset();
        chk("idle_after_reset", 64'(busy), 64'd0);

        // A: CPU0 read miss, CPU1 holds the block.
        bico0 = 13'h0040; search_found = 2'b10;
        expect_busy(2'b01, 2'b10, 13'h0, 13'h0040, 2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b01, 2'b00, 13'h0, 13'h0,    2'b00, 2'b01, 2'b00, 1'b0);
        read_miss = 2'b01; tick(); read_miss = 2'b00;
        repeat (3) tick();

        // B: CPU1 write miss, CPU0 does not hold it.
        bico1 = 13'h0100; search_found = 2'b00;
        expect_busy(2'b10, 2'b01, 13'h0100, 13'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b00, 13'h0,    13'h0, 2'b01, 2'b00, 2'b00, 1'b0);
        write_miss = 2'b10; tick(); write_miss = 2'b00;
        repeat (3) tick();

        // C: both mem_req after reset: CPU0 first, then CPU1 via rr.
        do_reset();
        repeat (3) expect_busy(2'b01, 2'b00, 13'h0, 13'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b00, 13'h0, 13'h0, 2'b00, 2'b00, 2'b00, 1'b1);
        mem_req = 2'b11;
        repeat (3) tick();
        mem_rdy = 1'b1; tick();
        mem_rdy = 1'b0; tick();
        mem_req = 2'b10; mem_rdy = 1'b1; tick();
        mem_req = 2'b00; mem_rdy = 1'b0; tick();
        chk("c_idle", 64'(busy), 64'd0);

        // D: CPU0 holds mem_req, mem_rdy never comes: 64 cycles then release.
        repeat (64) expect_busy(2'b01, 2'b00, 13'h0, 13'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        mem_req = 2'b01;
        repeat (65) tick();
        chk("d_forced_idle", 64'(busy), 64'd0);
        mem_req = 2'b00; tick();
`ifdef ARB_STATS_EN
        chk("timeout_cnt", 64'(timeout_cnt), 64'd1);
        chk("grant_cnt0", 64'(grant_cnt0), 64'd2);
        chk("grant_cnt1", 64'(grant_cnt1), 64'd1);
`endif

        // E: simultaneous invalidates: CPU0 first, CPU1 becomes a write miss.
        do_reset();
        bico0 = 13'h0040; bico1 = 13'h0100; search_found = 2'b00;
        expect_busy(2'b01, 2'b00, 13'h0,    13'h0040, 2'b10, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b01, 13'h0100, 13'h0,    2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b00, 13'h0,    13'h0,    2'b01, 2'b00, 2'b00, 1'b0);
        invalidate_req = 2'b11; tick(); invalidate_req = 2'b00;
        repeat (5) tick();
        chk("e_idle", 64'(busy), 64'd0);

        // G: a read miss arriving during MEM_XFER is held and serviced after.
        bico1 = 13'h0200; search_found = 2'b01;
        repeat (2) expect_busy(2'b01, 2'b00, 13'h0, 13'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b01, 13'h0200, 13'h0, 2'b00, 2'b00, 2'b00, 1'b0);
        expect_busy(2'b10, 2'b00, 13'h0,    13'h0, 2'b00, 2'b00, 2'b01, 1'b0);
        mem_req = 2'b01; tick();
        read_miss = 2'b10; tick();
        read_miss = 2'b00; mem_req = 2'b00;
        repeat (5) tick();
        chk("g_idle", 64'(busy), 64'd0);

        // F: reset asserted while in SNOOP.
        bico0 = 13'h0040; search_found = 2'b10;
        read_miss = 2'b01; tick(); read_miss = 2'b00;
        chk("f_in_snoop", 64'({busy, cpu_search, boci1}), 64'({1'b1, 2'b10, 13'h0040}));
        rst_n = 1'b0; #1;
        chk("f_async_outs", 64'({grant, cpu_search, inv_to, datasel0, datasel1,
                                 mem_owner, busy, boci0, boci1}), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("f_idle_after", 64'({busy, grant}), 64'd0);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msi_bus_arbiter.md
Name: msi_bus_arbiter

Overview:
- Arbitrates the shared snoop bus and the unified memory port between two cache_controller instances (CPU0, CPU1).
- Sequences each coherence transaction:
  - accept a request;
  - snoop the other cache for read/write misses;
  - select the data source;
  - broadcast invalidates;
  - hand the unified-memory port to the winner for evict/fill.
- Sits between the two cache controllers and the unified memory in the multicore top level.

Parameters:
- ADDR_W, 13, cache word-address width (BICO/BOCI width).
- SNOOP_LAT, 1, cycles between cpu_search assertion and sampling search_found (1..3).
- MEM_TIMEOUT, 64, max cycles in MEM_XFER before forced release.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  in  2  per-CPU unified-memory request (that controller's u_re|u_we)
- read_miss  in  2  per-CPU read-miss pulse
- write_miss  in  2  per-CPU write-miss pulse
- invalidate_req  in  2  per-CPU write-hit-on-SHARED invalidate pulse
- bico0, bico1  in  ADDR_W  each CPU's outgoing bus address
- search_found  in  2  per-CPU snoop hit (block valid in that cache)
- mem_rdy  in  1  unified memory ready
- grant  out  2  one-hot bus grant
- cpu_search  out  2  snoop request to the non-owner cache
- boci0, boci1  out  ADDR_W  address presented to each CPU's snoop port
- inv_to  out  2  invalidate_from_other_cpu, per CPU
- datasel0, datasel1  out  2  cpu_datasel per CPU: 2'b00 = DMEM, 2'b01 = OTHER_PROC
- mem_owner  out  1  CPU index driving unified memory address/data
- busy  out  1  any state other than IDLE

Behaviour:
- Reset values: all outputs 0; state = IDLE; round-robin pointer rr = 0 (CPU0 has priority).
- A request is any of mem_req / read_miss / write_miss / invalidate_req for a CPU. Miss and invalidate pulses are latched into per-CPU pending bits until serviced.
- IDLE:
  - No request: stay in IDLE.
  - One CPU requests: that CPU wins (owner o).
  - Both request: the CPU indicated by rr wins; rr flips to the loser on each grant.
  - grant[o] asserts the cycle after the win is registered (latency 1).
  - Next state, by request type (highest first):
    - invalidate → INV
    - read_miss or write_miss → SNOOP
    - mem_req only → MEM_XFER
- INV (1 cycle):
  - inv_to[~o] = 1; boci[~o] = bico[o]; clear pending.
  - Go to IDLE.
- SNOOP:
  - cpu_search[~o] = 1; boci[~o] = bico[o].
  - Hold SNOOP_LAT cycles, then sample search_found[~o] and go to RESP.
- RESP (1 cycle):
  - Snoop hit: datasel[o] = 01.
  - Snoop miss: datasel[o] = 00.
  - For a write_miss, inv_to[~o] = 1 in this cycle as well.
  - Then go to MEM_XFER if mem_req[o], else IDLE.
- MEM_XFER:
  - grant[o] stays high; mem_owner = o.
  - Exit to IDLE on mem_rdy & mem_req[o], or when mem_req[o] drops.
  - Timeout counter reaches MEM_TIMEOUT: force IDLE.
- Grant is held through back-to-back evict+fill. A re-asserted mem_req from the owner in the cycle of exit gets priority only via rr.
- Simultaneous events:
  - Both CPUs issue invalidate in the same cycle: only the rr winner's invalidate is honored first. The loser's pending bit is then re-evaluated as a write miss (its block was invalidated).
  - A pending bit set during another transaction is retained.
- Reset mid-transaction: immediate return to IDLE; all pending bits cleared; grant dropped.

Optional Feature:
- Macro: ARB_STATS_EN.
- When defined, adds outputs:
  - grant_cnt0, grant_cnt1 (16 b each): increment on each grant.
  - snoop_hit_cnt (16 b): increments in RESP on a snoop hit.
  - timeout_cnt (8 b): increments on each forced release.
  - All counters saturate and reset to 0.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add to package common:
  - arb_state_t enum {IDLE, INV, SNOOP, RESP, MEM_XFER};
  - SOURCE_DMEM and SOURCE_OTHER_PROC localparams, moved there so cache_controller shares them.
- Sub-module rr_arb2: two-requester round-robin picker with registered pointer.

Test Plan:
- CPU0 read_miss, bico0 = 13'h0040, CPU1 search_found = 1 → cpu_search[1] high, boci1 = 13'h0040, then datasel0 = 01 in RESP.
- CPU1 write_miss, bico1 = 13'h0100, CPU0 search_found = 0 → datasel1 = 00, inv_to[0] pulses 1 cycle, boci0 = 13'h0100.
- Both mem_req in the same cycle after reset → grant = 01 first; after mem_rdy, grant = 10.
- CPU0 mem_req held, mem_rdy never asserts → forced IDLE after 64 cycles; timeout_cnt = 1 with ARB_STATS_EN defined.
- CPU0 invalidate_req and CPU1 invalidate_req in the same cycle → inv_to = 10 first, then CPU1 serviced as a write miss via SNOOP.
- rst_n low while in SNOOP → all outputs 0 asynchronously; state IDLE after release.
